// File: rtl/instruction_fetch_unit.sv
// -----------------------------------------------------------------------------
// instruction_fetch_unit
//
// Purpose:
//   Single-stage instruction fetch front end. It issues a word-aligned fetch
//   address to a synchronous instruction memory and presents the returned
//   instruction to decode, together with its PC and a valid flag. It supports:
//   - decode back-pressure (STALL), with a one-entry hold buffer;
//   - control-flow redirects (REDIRECT), with a one-cycle bubble penalty;
//   - synchronous reset to a parameterised start address.
//
// Ports:
//   CLK          in   1   clock, all state updates on the rising edge
//   RESET        in   1   synchronous, active-high reset
//   IMEM_ADDR    out  32  fetch address to instruction memory (register pc_req)
//   IMEM_INSTR   in   32  memory data, mem[IMEM_ADDR] captured at previous edge
//   STALL        in   1   decode cannot accept; hold the current IF output
//   REDIRECT     in   1   taken branch/jump; restart fetch at REDIRECT_PC
//   REDIRECT_PC  in   32  redirect target (low two bits ignored)
//   IF_PC        out  32  PC of the instruction on IF_INSTR (register pc_out)
//   IF_INSTR     out  32  held instruction when hold_vld=1, else IMEM_INSTR
//   IF_VALID     out  1   IF_PC/IF_INSTR carry a real instruction (vld_out)
//
// Operating states, decoded from the registers:
//   BUBBLE : vld_out=0
//   RUN    : vld_out=1, hold_vld=0
//   HELD   : vld_out=1, hold_vld=1
// -----------------------------------------------------------------------------
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        CLK,
  input  logic        RESET,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_INSTR,
  input  logic        STALL,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic [31:0] IF_PC,
  output logic [31:0] IF_INSTR,
  output logic        IF_VALID
);

  // Fetch-request and fetch-output registers.
  logic [31:0] pc_req;
  logic [31:0] pc_out;
  logic        vld_out;
  logic [31:0] hold_instr;
  logic        hold_vld;

  logic [31:0] w_redirect_tgt;
  logic [31:0] w_pc_next;

  // Targets are forced to word alignment; masking (rather than slicing) keeps
  // every bit of REDIRECT_PC in use.
  assign w_redirect_tgt = REDIRECT_PC & 32'hFFFF_FFFC;

  // Sequential fetch; 32-bit modulo so 32'hFFFF_FFFC wraps to 0.
  assign w_pc_next = pc_req + 32'd4;

  // ---- request stage -> output stage boundary ----
  // Priority: RESET > REDIRECT > STALL > normal advance.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      pc_req     <= RESET_PC;
      pc_out     <= 32'h0000_0000;
      vld_out    <= 1'b0;
      hold_vld   <= 1'b0;
      hold_instr <= 32'h0000_0000;
    end else if (REDIRECT) begin
      // The word arriving next cycle belongs to the old path, so the output
      // goes invalid for one cycle and any held instruction is dropped.
      pc_req   <= w_redirect_tgt;
      pc_out   <= pc_req;
      vld_out  <= 1'b0;
      hold_vld <= 1'b0;
    end else if (STALL) begin
      // Memory returns a new word on every edge, so the word currently on
      // IMEM_INSTR must be captured on the first stalled edge or it is lost.
      // Later stalled edges leave everything alone.
      if (!hold_vld) begin
        hold_instr <= IMEM_INSTR;
        hold_vld   <= 1'b1;
      end
    end else begin
      // Normal advance (also the stall-release edge): the instruction on the
      // output is consumed and pc_req's word, now arriving from memory,
      // becomes the new output.
      pc_out   <= pc_req;
      vld_out  <= 1'b1;
      pc_req   <= w_pc_next;
      hold_vld <= 1'b0;
    end
  end

  // ---- output stage ----
  assign IMEM_ADDR = pc_req;
  assign IF_PC     = pc_out;
  assign IF_VALID  = vld_out;
  assign IF_INSTR  = hold_vld ? hold_instr : IMEM_INSTR;

endmodule
